// File: rtl/regbank_pkg.sv
// Shared types and helpers for the multi-port register bank.
// Helpers work on a fixed maximum width; callers cast to and from their own WIDTH.
package regbank_pkg;

    localparam int unsigned MAX_W  = 64;
    localparam int unsigned MAX_BE = MAX_W / 8;

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    // Byte-wise merge: bytes with be=1 come from new_word, the rest from old_word.
    function automatic logic [MAX_W-1:0] be_merge(input logic [MAX_W-1:0] old_word,
                                                  input logic [MAX_W-1:0] new_word,
                                                  input logic [MAX_BE-1:0] be);
        logic [MAX_W-1:0] mask;
        for (int k = 0; k < int'(MAX_BE); k++) begin
            mask[k*8 +: 8] = {8{be[k]}};
        end
        return (old_word & ~mask) | (new_word & mask);
    endfunction

    function automatic logic [MAX_W-1:0] rst_val(input int unsigned addr,
                                                 input int unsigned id_addr,
                                                 input logic [MAX_W-1:0] id_value);
        return (addr == id_addr) ? id_value : '0;
    endfunction

endpackage

// File: rtl/regbank_rd_port.sv
// One registered read port: latency 1, holds its value when idle, optional
// read-during-write bypass of the word being written this cycle.
module regbank_rd_port #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AW     = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_r_en,
    input  logic [AW-1:0]    i_r_addr,
    input  logic [WIDTH-1:0] i_mem_word,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_r_value,
    output logic             o_r_valid
);

    logic [WIDTH-1:0] value_q, value_d;
    logic             valid_q;

    always_comb begin
        value_d = value_q;
        if (i_r_en) begin
            // i_wr_en only ever qualifies an in-range address, so out-of-range reads stay 0
            if (BYPASS && i_wr_en && (i_wr_addr == i_r_addr)) begin
                value_d = i_wr_data;
            end else begin
                value_d = i_mem_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            valid_q <= 1'b0;
        end else begin
            value_q <= value_d;
            valid_q <= i_r_en;
        end
    end

    assign o_r_value = value_q;
    assign o_r_valid = valid_q;

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port configuration/status register bank: N_RD registered read ports, one
// byte-enabled write port, read-only mask, constant ID register and bulk-clear sequencer.
module register_bank_mp import regbank_pkg::*; #(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      DEPTH    = 32,
    parameter int unsigned      N_RD     = 2,
    parameter int unsigned      ID_ADDR  = 0,
    parameter logic [WIDTH-1:0] ID_VALUE = 'hb00,
    parameter logic [DEPTH-1:0] RO_MASK  = DEPTH'(1) << ID_ADDR,
    parameter bit               BYPASS   = 1'b1,
    localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned     BE_W     = WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_w_en,
    input  logic [AW-1:0]         i_w_addr,
    input  logic [WIDTH-1:0]      i_w_value,
    input  logic [BE_W-1:0]       i_w_be,
    input  logic [N_RD-1:0]       i_r_en,
    input  logic [N_RD*AW-1:0]    i_r_addr,
    output logic [N_RD*WIDTH-1:0] o_r_value,
    output logic [N_RD-1:0]       o_r_valid,
    output logic                  o_w_err,
    input  logic                  i_clr_req,
    output logic                  o_busy,
    output logic                  o_clr_done
);

    localparam logic [AW:0] DEPTH_EXT = (AW + 1)'(DEPTH);

    clr_state_t       state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             w_in_range, w_ro, w_accept, w_err_q;
    logic [WIDTH-1:0] w_old, w_merged;
    logic             clr_we;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    // Write qualification and byte merge against the current word
    always_comb begin
        w_in_range = ({1'b0, i_w_addr} < DEPTH_EXT);
        w_ro       = 1'b0;
        w_old      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_w_addr == AW'(i)) begin
                w_ro  = RO_MASK[i];
                w_old = mem_q[i];
            end
        end
        w_accept = i_w_en && w_in_range && !w_ro && (state_q == IDLE);
        w_merged = WIDTH'(be_merge(MAX_W'(w_old), MAX_W'(i_w_value), MAX_BE'(i_w_be)));
    end

    // Single effective write: host write in IDLE, or the clear pointer in CLEAR
    always_comb begin
        clr_we  = (state_q == CLEAR);
        wr_en   = w_accept || clr_we;
        wr_addr = clr_we ? ptr_q : i_w_addr;
        wr_data = clr_we ? WIDTH'(rst_val(32'(ptr_q), ID_ADDR, MAX_W'(ID_VALUE))) : w_merged;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(rst_val(i, ID_ADDR, MAX_W'(ID_VALUE)));
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    mem_q[i] <= wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_err_q <= 1'b0;
        end else begin
            w_err_q <= i_w_en && !w_accept;
        end
    end

    assign o_w_err = w_err_q;

    // Clear FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Clear FSM: next state
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (i_clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            CLEAR: begin
                if (ptr_q == AW'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Clear FSM: outputs
    always_comb begin
        o_busy     = (state_q == CLEAR);
        o_clr_done = (state_q == DONE);
    end

    for (genvar p = 0; p < int'(N_RD); p++) begin : g_rd_port
        logic [AW-1:0]    rd_addr;
        logic [WIDTH-1:0] rd_word;

        always_comb begin
            rd_addr = i_r_addr[p*AW +: AW];
            rd_word = '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_addr == AW'(i)) begin
                    rd_word = mem_q[i];
                end
            end
        end

        regbank_rd_port #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .BYPASS(BYPASS)
        ) u_rd_port (
            .clk       (clk),
            .reset     (reset),
            .i_r_en    (i_r_en[p]),
            .i_r_addr  (rd_addr),
            .i_mem_word(rd_word),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_r_value (o_r_value[p*WIDTH +: WIDTH]),
            .o_r_valid (o_r_valid[p])
        );
    end

endmodule

// File: tb/tb_register_bank_mp.sv
// Bench for register_bank_mp: two instances (DEPTH=32/BYPASS=1 and DEPTH=20/BYPASS=0)
// share stimulus; a behavioural model predicts both every cycle.
module tb_register_bank_mp;

    localparam int AW = 5;

    logic        clk = 1'b0;
    logic        reset, w_en, clr_req;
    logic [4:0]  w_addr;
    logic [15:0] w_value;
    logic [1:0]  w_be, r_en;
    logic [9:0]  r_addr;

    logic [31:0] r_value_a, r_value_b;
    logic [1:0]  r_valid_a, r_valid_b;
    logic        w_err_a, w_err_b, busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    register_bank_mp #(.WIDTH(16), .DEPTH(32), .N_RD(2), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .i_w_en(w_en), .i_w_addr(w_addr), .i_w_value(w_value),
        .i_w_be(w_be), .i_r_en(r_en), .i_r_addr(r_addr), .o_r_value(r_value_a),
        .o_r_valid(r_valid_a), .o_w_err(w_err_a), .i_clr_req(clr_req), .o_busy(busy_a),
        .o_clr_done(done_a)
    );

    register_bank_mp #(.WIDTH(16), .DEPTH(20), .N_RD(2), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .i_w_en(w_en), .i_w_addr(w_addr), .i_w_value(w_value),
        .i_w_be(w_be), .i_r_en(r_en), .i_r_addr(r_addr), .o_r_value(r_value_b),
        .o_r_valid(r_valid_b), .o_w_err(w_err_b), .i_clr_req(clr_req), .o_busy(busy_b),
        .o_clr_done(done_b)
    );

    // Reference model, one slot per configuration (0 = instance a, 1 = instance b)
    logic [15:0] m_mem [2][32];
    logic [15:0] m_rv  [2][2];
    logic        m_vld [2][2];
    logic        m_err [2];
    int          m_clr [2];   // -1 idle, 0..d-1 clearing that register, d = done cycle

    function automatic int depth_of(input int c);
        return (c == 0) ? 32 : 20;
    endfunction

    function automatic bit bypass_of(input int c);
        return (c == 0);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = o;
        for (int k = 0; k < 2; k++) if (be[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_in();
        reset = 1'b0; w_en = 1'b0; clr_req = 1'b0; r_en = 2'b00;
        w_addr = '0; w_value = '0; w_be = '0; r_addr = '0;
    endtask

    // Predict one clock edge for both configurations, then compare after the edge
    task automatic step();
        for (int c = 0; c < 2; c++) begin
            int d, wa, a;
            bit idle, acc, wr;
            logic [15:0] wd;
            d    = depth_of(c);
            idle = (m_clr[c] < 0);
            acc  = w_en && (int'(w_addr) < d) && (w_addr != 5'd0) && idle;
            wr = 1'b0; wa = 0; wd = '0;
            if (acc) begin
                wr = 1'b1; wa = int'(w_addr); wd = merge(m_mem[c][wa], w_value, w_be);
            end else if (m_clr[c] >= 0 && m_clr[c] < d) begin
                wr = 1'b1; wa = m_clr[c]; wd = (wa == 0) ? 16'hb00 : 16'h0000;
            end
            for (int p = 0; p < 2; p++) begin
                if (r_en[p]) begin
                    a = int'(r_addr[p*AW +: AW]);
                    if (wr && wa == a && bypass_of(c)) m_rv[c][p] = wd;
                    else if (a < d)                    m_rv[c][p] = m_mem[c][a];
                    else                               m_rv[c][p] = 16'h0000;
                    m_vld[c][p] = 1'b1;
                end else begin
                    m_vld[c][p] = 1'b0;
                end
            end
            m_err[c] = w_en && !acc;
            if (wr) m_mem[c][wa] = wd;
            if (m_clr[c] < 0) begin
                if (clr_req) m_clr[c] = 0;
            end else if (m_clr[c] >= d) begin
                m_clr[c] = -1;
            end else begin
                m_clr[c]++;
            end
            if (reset) begin
                for (int i = 0; i < 32; i++) m_mem[c][i] = (i == 0) ? 16'hb00 : 16'h0000;
                for (int p = 0; p < 2; p++) begin m_rv[c][p] = '0; m_vld[c][p] = 1'b0; end
                m_err[c] = 1'b0;
                m_clr[c] = -1;
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 2; c++) begin
            logic [31:0] rv;
            logic [1:0]  vl;
            logic        er, bz, dn;
            rv = (c == 0) ? r_value_a : r_value_b;
            vl = (c == 0) ? r_valid_a : r_valid_b;
            er = (c == 0) ? w_err_a   : w_err_b;
            bz = (c == 0) ? busy_a    : busy_b;
            dn = (c == 0) ? done_a    : done_b;
            check($sformatf("cfg%0d r_value", c), 64'(rv), 64'({m_rv[c][1], m_rv[c][0]}));
            check($sformatf("cfg%0d r_valid", c), 64'(vl), 64'({m_vld[c][1], m_vld[c][0]}));
            check($sformatf("cfg%0d w_err", c), 64'(er), 64'(m_err[c]));
            check($sformatf("cfg%0d busy", c), 64'(bz),
                  64'(m_clr[c] >= 0 && m_clr[c] < depth_of(c)));
            check($sformatf("cfg%0d clr_done", c), 64'(dn), 64'(m_clr[c] == depth_of(c)));
        end
    endtask

    typedef struct {
        bit          w_en;
        logic [4:0]  w_addr;
        logic [15:0] w_value;
        logic [1:0]  w_be;
        logic [1:0]  r_en;
        logic [4:0]  ra0, ra1;
        logic [15:0] e0, e1;
        logic [1:0]  ev;
        bit          eerr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt_a, cnt_b, dn_a, dn_b;

        vecs[0] = '{1'b0, 5'd0,  16'h0000, 2'b00, 2'b11, 5'd0,  5'd5,  16'h0b00, 16'h0000, 2'b11, 1'b0};
        vecs[1] = '{1'b1, 5'd3,  16'h1234, 2'b11, 2'b00, 5'd0,  5'd0,  16'h0b00, 16'h0000, 2'b00, 1'b0};
        vecs[2] = '{1'b1, 5'd3,  16'hABCD, 2'b10, 2'b00, 5'd0,  5'd0,  16'h0b00, 16'h0000, 2'b00, 1'b0};
        vecs[3] = '{1'b0, 5'd0,  16'h0000, 2'b00, 2'b11, 5'd3,  5'd3,  16'hAB34, 16'hAB34, 2'b11, 1'b0};
        vecs[4] = '{1'b1, 5'd0,  16'hFFFF, 2'b11, 2'b00, 5'd0,  5'd0,  16'hAB34, 16'hAB34, 2'b00, 1'b1};
        vecs[5] = '{1'b0, 5'd0,  16'h0000, 2'b00, 2'b11, 5'd0,  5'd3,  16'h0b00, 16'hAB34, 2'b11, 1'b0};
        vecs[6] = '{1'b1, 5'd7,  16'h1111, 2'b11, 2'b00, 5'd0,  5'd0,  16'h0b00, 16'hAB34, 2'b00, 1'b0};
        vecs[7] = '{1'b1, 5'd7,  16'h5A5A, 2'b01, 2'b11, 5'd7,  5'd7,  16'h115A, 16'h115A, 2'b11, 1'b0};
        vecs[8] = '{1'b0, 5'd0,  16'h0000, 2'b00, 2'b11, 5'd7,  5'd7,  16'h115A, 16'h115A, 2'b11, 1'b0};
        vecs[9] = '{1'b1, 5'd31, 16'h0F0F, 2'b11, 2'b11, 5'd31, 5'd25, 16'h0F0F, 16'h0000, 2'b11, 1'b0};

        for (int c = 0; c < 2; c++) m_clr[c] = -1;

        // Reset
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset r_value", 64'(r_value_a), 64'h0);
        check("reset busy", 64'({busy_a, done_a, w_err_a}), 64'h0);

        // Directed vectors (instance a expectations)
        for (int i = 0; i < 10; i++) begin
            w_en = vecs[i].w_en; w_addr = vecs[i].w_addr; w_value = vecs[i].w_value;
            w_be = vecs[i].w_be; r_en = vecs[i].r_en; r_addr = {vecs[i].ra1, vecs[i].ra0};
            step();
            check($sformatf("vec%0d r0", i), 64'(r_value_a[15:0]), 64'(vecs[i].e0));
            check($sformatf("vec%0d r1", i), 64'(r_value_a[31:16]), 64'(vecs[i].e1));
            check($sformatf("vec%0d valid", i), 64'(r_valid_a), 64'(vecs[i].ev));
            check($sformatf("vec%0d w_err", i), 64'(w_err_a), 64'(vecs[i].eerr));
        end
        idle_in();

        // DEPTH=20 instance: out-of-range write/read and last register
        w_en = 1'b1; w_addr = 5'd19; w_value = 16'h0F0F; w_be = 2'b11;
        step();
        w_addr = 5'd25; w_value = 16'h1234;
        step();
        check("d20 write 25 err", 64'(w_err_b), 64'h1);
        check("d32 write 25 ok", 64'(w_err_a), 64'h0);
        idle_in();
        r_en = 2'b11; r_addr = {5'd25, 5'd19};
        step();
        check("d20 read 19", 64'(r_value_b[15:0]), 64'h0F0F);
        check("d20 read 25", 64'(r_value_b[31:16]), 64'h0);
        check("d20 valid", 64'(r_valid_b), 64'h3);

        // Same-cycle read of a partially written word, both bypass settings
        idle_in();
        w_en = 1'b1; w_addr = 5'd9; w_value = 16'h1111; w_be = 2'b11;
        step();
        w_value = 16'h5A5A; w_be = 2'b01; r_en = 2'b11; r_addr = {5'd9, 5'd9};
        step();
        check("bypass1 new word", 64'(r_value_a), 64'h115A115A);
        check("bypass0 old word", 64'(r_value_b), 64'h11111111);

        // Fill everything, then clear with a mid-clear write and a stray request
        idle_in();
        for (int a = 0; a < 32; a++) begin
            w_en = 1'b1; w_addr = 5'(a); w_value = 16'hFFFF; w_be = 2'b11;
            step();
        end
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        cnt_a = 0; cnt_b = 0; dn_a = 0; dn_b = 0;
        for (int k = 0; k < 60; k++) begin
            if (busy_a) cnt_a++;
            if (busy_b) cnt_b++;
            if (done_a) dn_a++;
            if (done_b) dn_b++;
            w_en = (k == 5); w_addr = 5'd10; w_value = 16'h7777; w_be = 2'b11;
            clr_req = (k == 8);
            step();
            if (k == 5) check("mid-clear write err", 64'({w_err_a, w_err_b}), 64'h3);
        end
        check("clear busy cycles a", 64'(cnt_a), 64'd32);
        check("clear busy cycles b", 64'(cnt_b), 64'd20);
        check("clear done pulses", 64'({dn_a[7:0], dn_b[7:0]}), 64'h0101);
        idle_in();
        for (int a = 0; a < 32; a += 2) begin
            r_en = 2'b11; r_addr = {5'(a + 1), 5'(a)};
            step();
            check($sformatf("after clear addr %0d", a), 64'(r_value_a),
                  (a == 0) ? 64'h00000b00 : 64'h0);
        end

        // Reset during a clear abandons it without a done pulse
        idle_in();
        w_en = 1'b1; w_addr = 5'd4; w_value = 16'h1234; w_be = 2'b11;
        step();
        idle_in();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset mid-clear busy", 64'({busy_a, busy_b}), 64'h0);
        dn_a = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done_a || done_b) dn_a++;
        end
        check("no done after reset", 64'(dn_a), 64'h0);
        r_en = 2'b11; r_addr = {5'd4, 5'd0};
        step();
        check("reset values", 64'(r_value_a), 64'h00000b00);

        // Randomised traffic against the model
        idle_in();
        for (int n = 0; n < 1500; n++) begin
            reset   = ($urandom_range(0, 299) == 0);
            clr_req = ($urandom_range(0, 49) == 0);
            w_en    = 1'($urandom_range(0, 1));
            w_addr  = 5'($urandom_range(0, 31));
            w_value = 16'($urandom);
            w_be    = 2'($urandom_range(0, 3));
            r_en    = 2'($urandom_range(0, 3));
            r_addr  = 10'($urandom);
            if ($urandom_range(0, 2) == 0) r_addr[4:0] = w_addr;
            if ($urandom_range(0, 2) == 0) r_addr[9:5] = w_addr;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
